// File: rtl/lcd_layer_mixer_pkg.sv
// rtl/lcd_layer_mixer_pkg.sv - shared timing defaults, layer indices and colour helpers
// Raster positions are 11 bits, so each timing total is limited to 2048.
package lcd_layer_mixer_pkg;

    localparam int POS_W         = 11;
    localparam int POS_MAX_TOTAL = 2048;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 40;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;
    localparam int DEF_N_LAYERS = 4;
    localparam logic [23:0] DEF_BG_COLOR = 24'h000000;

    typedef enum logic [1:0] {
        LAYER_GUN   = 2'd0,
        LAYER_ENEMY = 2'd1,
        LAYER_SHOT  = 2'd2,
        LAYER_HUD   = 2'd3
    } layer_id_e;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } lcd_ctrl_t;

    localparam lcd_ctrl_t CTRL_BLANK = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1};

    // Replicate the top bits into the low bits so full-scale 565 maps to full-scale 888.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
        return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
    endfunction

endpackage

// File: rtl/lcd_layer_mixer_timing_gen.sv
// rtl/lcd_layer_mixer_timing_gen.sv - raster counters, sync/DE decode and frame_start
// Order per axis: active, front porch, sync, back porch.
module lcd_layer_mixer_timing_gen
    import lcd_layer_mixer_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [POS_W-1:0] o_xpos,
    output logic [POS_W-1:0] o_ypos,
    output lcd_ctrl_t        o_ctrl,
    output logic             o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);

    logic [POS_W-1:0] r_xpos;
    logic [POS_W-1:0] r_ypos;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_xpos <= '0;
            r_ypos <= '0;
        end else if (r_xpos == H_LAST) begin
            r_xpos <= '0;
            r_ypos <= (r_ypos == V_LAST) ? '0 : r_ypos + 1'b1;
        end else begin
            r_xpos <= r_xpos + 1'b1;
        end
    end

    // Compare as int so an active width of exactly 2048 cannot wrap the bound.
    always_comb begin
        o_ctrl.de    = (int'(r_xpos) < H_ACTIVE) && (int'(r_ypos) < V_ACTIVE);
        o_ctrl.hsync = !((int'(r_xpos) >= H_ACTIVE + H_FP) &&
                         (int'(r_xpos) <  H_ACTIVE + H_FP + H_SYNC));
        o_ctrl.vsync = !((int'(r_ypos) >= V_ACTIVE + V_FP) &&
                         (int'(r_ypos) <  V_ACTIVE + V_FP + V_SYNC));
    end

    assign o_xpos        = r_xpos;
    assign o_ypos        = r_ypos;
    assign o_frame_start = !i_rst && (r_xpos == '0) && (r_ypos == '0);

endmodule

// File: rtl/lcd_layer_mixer.sv
// rtl/lcd_layer_mixer.sv - LCD raster source and fixed-priority layer compositor
// Optional per-layer collision flags under MIXER_COLLISION_EN.
module lcd_layer_mixer
    import lcd_layer_mixer_pkg::*;
#(
    parameter int          H_ACTIVE = DEF_H_ACTIVE,
    parameter int          H_FP     = DEF_H_FP,
    parameter int          H_SYNC   = DEF_H_SYNC,
    parameter int          H_BP     = DEF_H_BP,
    parameter int          V_ACTIVE = DEF_V_ACTIVE,
    parameter int          V_FP     = DEF_V_FP,
    parameter int          V_SYNC   = DEF_V_SYNC,
    parameter int          V_BP     = DEF_V_BP,
    parameter int          N_LAYERS = DEF_N_LAYERS,
    parameter logic [23:0] BG_COLOR = DEF_BG_COLOR
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic [POS_W-1:0]       o_lcd_xpos,
    output logic [POS_W-1:0]       o_lcd_ypos,
    input  logic [24*N_LAYERS-1:0] i_layer_pixel,
    input  logic [N_LAYERS-1:0]    i_layer_valid,
    output logic                   o_lcd_de,
    output logic                   o_lcd_hsync,
    output logic                   o_lcd_vsync,
    output logic [23:0]            o_lcd_data,
    output logic                   o_frame_start
`ifdef MIXER_COLLISION_EN
    ,
    output logic [N_LAYERS-1:0]    o_collision
`endif
);

    generate
        if ((H_ACTIVE + H_FP + H_SYNC + H_BP > POS_MAX_TOTAL) ||
            (V_ACTIVE + V_FP + V_SYNC + V_BP > POS_MAX_TOTAL)) begin : g_bad_timing
            $error("lcd_layer_mixer: H or V total exceeds 2048");
        end
        if ((N_LAYERS < 1) || (N_LAYERS > 8)) begin : g_bad_layers
            $error("lcd_layer_mixer: N_LAYERS must be 1..8");
        end
    endgenerate

    logic [POS_W-1:0] w_xpos;
    logic [POS_W-1:0] w_ypos;
    lcd_ctrl_t        w_ctrl0;
    logic [23:0]      w_mix;

    lcd_ctrl_t        r_ctrl1;
    lcd_ctrl_t        r_ctrl2;
    logic [23:0]      r_data;

    lcd_layer_mixer_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_xpos        (w_xpos),
        .o_ypos        (w_ypos),
        .o_ctrl        (w_ctrl0),
        .o_frame_start (o_frame_start)
    );

    // Scan from lowest priority upward so the lowest valid index wins.
    always_comb begin
        w_mix = BG_COLOR;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (i_layer_valid[i]) begin
                w_mix = i_layer_pixel[24*i +: 24];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ctrl1 <= CTRL_BLANK;
            r_ctrl2 <= CTRL_BLANK;
            r_data  <= '0;
        end else begin
            r_ctrl1 <= w_ctrl0;
            r_ctrl2 <= r_ctrl1;
            r_data  <= r_ctrl1.de ? w_mix : 24'h0;
        end
    end

    assign o_lcd_xpos  = w_xpos;
    assign o_lcd_ypos  = w_ypos;
    assign o_lcd_de    = r_ctrl2.de;
    assign o_lcd_hsync = r_ctrl2.hsync;
    assign o_lcd_vsync = r_ctrl2.vsync;
    assign o_lcd_data  = r_data;

`ifdef MIXER_COLLISION_EN
    logic                w_last0;
    logic [N_LAYERS-1:0] w_overlap;
    logic                r_last1;
    logic [N_LAYERS-1:0] r_flags;
    logic [N_LAYERS-1:0] r_collision;

    assign w_last0 = (int'(w_xpos) == H_ACTIVE - 1) && (int'(w_ypos) == V_ACTIVE - 1);

    always_comb begin
        w_overlap = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            w_overlap[i] = i_layer_valid[i] &&
                           |(i_layer_valid & ~(N_LAYERS'(1) << i));
        end
    end

    // The last active pixel's own overlap is folded in as the flags are published.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last1     <= 1'b0;
            r_flags     <= '0;
            r_collision <= '0;
        end else begin
            r_last1 <= w_last0;
            if (r_last1) begin
                r_collision <= r_flags | (r_ctrl1.de ? w_overlap : '0);
                r_flags     <= '0;
            end else if (r_ctrl1.de) begin
                r_flags <= r_flags | w_overlap;
            end
        end
    end

    assign o_collision = r_collision;
`endif

endmodule

// File: tb/tb_lcd_layer_mixer.sv
// tb/tb_lcd_layer_mixer.sv - randomized bench for lcd_layer_mixer against a raster-rule model
`timescale 1ns/1ps
module tb_lcd_layer_mixer;
    import lcd_layer_mixer_pkg::*;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NL = 4;
    localparam logic [23:0] BG = 24'h102030;

    localparam int M_RAND = 0, M_SINGLE = 1, M_PAIR = 2, M_COLL = 3, M_NONE = 4;

    typedef struct {
        logic          de;
        logic          hs;
        logic          vs;
        logic [23:0]   data;
        logic          upd;
        logic [NL-1:0] coll;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [10:0]      lcd_xpos, lcd_ypos;
    logic [24*NL-1:0] layer_pixel = '0;
    logic [NL-1:0]    layer_valid = '0;
    logic             lcd_de, lcd_hsync, lcd_vsync, frame_start;
    logic [23:0]      lcd_data;
`ifdef MIXER_COLLISION_EN
    logic [NL-1:0]    collision;
`endif

    lcd_layer_mixer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .N_LAYERS (NL), .BG_COLOR (BG)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_lcd_xpos    (lcd_xpos),
        .o_lcd_ypos    (lcd_ypos),
        .i_layer_pixel (layer_pixel),
        .i_layer_valid (layer_valid),
        .o_lcd_de      (lcd_de),
        .o_lcd_hsync   (lcd_hsync),
        .o_lcd_vsync   (lcd_vsync),
        .o_lcd_data    (lcd_data),
        .o_frame_start (frame_start)
`ifdef MIXER_COLLISION_EN
        ,
        .o_collision   (collision)
`endif
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            mode   = M_RAND;
    int            mx     = 0;
    int            my     = 0;
    int            fs_count, de_count, red_count;
    logic [24*NL-1:0] pend_pix;
    logic [NL-1:0]    pend_val;
    logic [NL-1:0]    m_flags   = '0;
    logic [NL-1:0]    exp_coll  = '0;
    exp_t             q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)", tag, got, exp, mx, my);
        end
    endtask

    task automatic gen_content(input int x, input int y);
        pend_pix = '0;
        pend_val = '0;
        case (mode)
            M_RAND: for (int i = 0; i < NL; i++) begin
                pend_val[i]          = ($urandom_range(0, 2) == 0);
                pend_pix[24*i +: 24] = 24'($urandom);
            end
            M_SINGLE: if (x == 3 && y == 1) begin
                pend_val[2]      = 1'b1;
                pend_pix[48+:24] = 24'hFF0000;
            end
            M_PAIR: begin
                pend_val[1:0]   = 2'b11;
                pend_pix[0+:24] = 24'h00FF00;
                pend_pix[24+:24] = 24'h0000FF;
            end
            M_COLL: if (x == 4 && y == 2) begin
                pend_val[0]     = 1'b1;
                pend_val[3]     = 1'b1;
                pend_pix[0+:24] = 24'hABCDEF;
                pend_pix[72+:24] = 24'h456789;
            end
            default: ;
        endcase
    endtask

    // Expected pins for the position presented now, from the raster and priority rules.
    task automatic model(input int x, input int y, output exp_t e);
        e.de   = (x < HA) && (y < VA);
        e.hs   = !(x >= HA + HF && x < HA + HF + HS);
        e.vs   = !(y >= VA + VF && y < VA + VF + VS);
        e.data = 24'h0;
        e.upd  = 1'b0;
        e.coll = '0;
        if (e.de) begin
            e.data = BG;
            for (int i = NL - 1; i >= 0; i--)
                if (pend_val[i]) e.data = pend_pix[24*i +: 24];
            if ($countones(pend_val) > 1) m_flags = m_flags | pend_val;
        end
        if (x == HA - 1 && y == VA - 1) begin
            e.upd   = 1'b1;
            e.coll  = m_flags;
            m_flags = '0;
        end
    endtask

    task automatic push_current();
        exp_t n;
        gen_content(mx, my);
        model(mx, my, n);
        q.push_back(n);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        layer_pixel = pend_pix;
        layer_valid = pend_val;
        mx++;
        if (mx == HT) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end
        @(negedge clk);
        e = q.pop_front();
        check_eq("de",    32'(lcd_de),    32'(e.de));
        check_eq("hsync", 32'(lcd_hsync), 32'(e.hs));
        check_eq("vsync", 32'(lcd_vsync), 32'(e.vs));
        check_eq("data",  32'(lcd_data),  32'(e.data));
        if (e.upd) exp_coll = e.coll;
`ifdef MIXER_COLLISION_EN
        check_eq("collision", 32'(collision), 32'(exp_coll));
`endif
        check_eq("xpos", 32'(lcd_xpos), 32'(mx));
        check_eq("ypos", 32'(lcd_ypos), 32'(my));
        check_eq("frame_start", 32'(frame_start), 32'(mx == 0 && my == 0));
        if (frame_start) fs_count++;
        if (lcd_de) de_count++;
        if (lcd_de && lcd_data == 24'hFF0000) red_count++;
        push_current();
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_xpos"},  32'(lcd_xpos),    32'd0);
        check_eq({tag, "_ypos"},  32'(lcd_ypos),    32'd0);
        check_eq({tag, "_de"},    32'(lcd_de),      32'd0);
        check_eq({tag, "_hsync"}, 32'(lcd_hsync),   32'd1);
        check_eq({tag, "_vsync"}, 32'(lcd_vsync),   32'd1);
        check_eq({tag, "_data"},  32'(lcd_data),    32'd0);
        check_eq({tag, "_fs"},    32'(frame_start), 32'd0);
`ifdef MIXER_COLLISION_EN
        check_eq({tag, "_coll"},  32'(collision),   32'd0);
`endif
    endtask

    task automatic release_rst();
        exp_t blank;
        blank = '{de: 1'b0, hs: 1'b1, vs: 1'b1, data: 24'h0, upd: 1'b0, coll: '0};
        rst = 1'b0;
        #1;
        mx = 0;
        my = 0;
        m_flags  = '0;
        exp_coll = '0;
        q.delete();
        q.push_back(blank);
        check_eq("rel_xpos", 32'(lcd_xpos),    32'd0);
        check_eq("rel_ypos", 32'(lcd_ypos),    32'd0);
        check_eq("rel_fs",   32'(frame_start), 32'd1);
        push_current();
    endtask

    task automatic run_frame(input int m);
        mode = m;
        repeat (HT * VT) tick();
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        release_rst();

        fs_count = 0; de_count = 0;
        run_frame(M_RAND);
        run_frame(M_RAND);
        check_eq("fs_pulses_2frames", 32'(fs_count), 32'd2);
        check_eq("de_clocks_2frames", 32'(de_count), 32'(2 * HA * VA));

        run_frame(M_NONE);
        red_count = 0;
        run_frame(M_SINGLE);
        check_eq("single_red_pixels", 32'(red_count), 32'd1);
        run_frame(M_PAIR);
        run_frame(M_NONE);
        run_frame(M_COLL);
`ifdef MIXER_COLLISION_EN
        check_eq("coll_after_overlap", 32'(collision), 32'b1001);
`endif
        run_frame(M_NONE);
`ifdef MIXER_COLLISION_EN
        check_eq("coll_after_clean", 32'(collision), 32'b0000);
`endif

        mode = M_RAND;
        for (int n = 0; n < HT * VT && !(mx == 5 && my == 2); n++) tick();
        check_eq("reached_5_2", 32'(mx == 5 && my == 2), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        repeat (3) begin
            @(negedge clk);
            check_reset("midrst_hold");
        end
        release_rst();
        fs_count = 0; de_count = 0;
        run_frame(M_RAND);
        check_eq("fs_after_reset", 32'(fs_count), 32'd1);
        check_eq("de_after_reset", 32'(de_count), 32'(HA * VA));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
